pc_reg: RTL and testbench



---
 rtl/pc_reg_if.sv | 67 ++++++
 rtl/pc_reg.sv | 97 +++++++++
 tb/tb_pc_reg.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/pc_reg_if.sv
// -----------------------------------------------------------------------------
// pc_reg_if
//
// Purpose:
//   Bundles the program-counter register's data signals so that the core's
//   next-PC logic and the PC register can share one port.
//
// Parameters:
//   XLEN            width of the PC and of every address signal.
//
// Signals:
//   pc_next         next program-counter value chosen by the next-PC mux.
//   pc              current program counter (registered in pc_reg).
//   pc_plus4        sequential address, pc + 4 modulo 2^XLEN.
//   pc_valid        high once the first post-reset address is presented.
//   pc_misaligned   (PC_ALIGN_CHECK_EN only) last loaded pc_next had
//                   non-zero low two bits.
//
// Modports:
//   master          next-PC / fetch side: drives pc_next, observes the rest.
//   slave           pc_reg side: observes pc_next, drives the rest.
//
// Configuration macro:
//   PC_ALIGN_CHECK_EN   adds the pc_misaligned signal to both modports.
// -----------------------------------------------------------------------------
interface pc_reg_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            pc_valid;

`ifdef PC_ALIGN_CHECK_EN
    logic            pc_misaligned;

    modport master (
        output pc_next,
        input  pc,
        input  pc_plus4,
        input  pc_valid,
        input  pc_misaligned
    );

    modport slave (
        input  pc_next,
        output pc,
        output pc_plus4,
        output pc_valid,
        output pc_misaligned
    );
`else
    modport master (
        output pc_next,
        input  pc,
        input  pc_plus4,
        input  pc_valid
    );

    modport slave (
        input  pc_next,
        output pc,
        output pc_plus4,
        output pc_valid
    );
`endif
endinterface

// File: rtl/pc_reg.sv
// -----------------------------------------------------------------------------
// pc_reg
//
// Purpose:
//   Program-counter state register for the single-cycle RISC-V core. Holds
//   the address of the instruction currently being fetched, loads the value
//   chosen by the next-PC mux on every rising clock edge (no enable, no
//   stall), and offers the sequential address pc + 4 plus a post-reset valid
//   flag to the fetch / next-PC logic.
//
// Parameters:
//   XLEN            width of the PC and all address signals (default 32).
//   RESET_VECTOR    address held while rst is asserted; must be 4-byte
//                   aligned (default 0).
//
// Ports:
//   clk             system clock, all state changes on the rising edge.
//   rst             asynchronous, active-high reset.
//   bus (slave)     pc_next in; pc, pc_plus4, pc_valid
//                   (and pc_misaligned) out.
//
// Configuration macro:
//   PC_ALIGN_CHECK_EN   when defined, pc loads pc_next with its low two bits
//                       cleared, and a registered pc_misaligned flag reports
//                       whether the loaded pc_next had non-zero low bits.
//                       When undefined, pc_next is loaded verbatim and the
//                       pc_misaligned signal does not exist.
//
// Every output comes from a register or from logic fed only by pc_q, so
// there is no combinational path from pc_next to any output.
// -----------------------------------------------------------------------------
module pc_reg #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic      clk,
    input  logic      rst,
    pc_reg_if.slave   bus
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic            valid_q;

`ifdef PC_ALIGN_CHECK_EN
    logic            misaligned_q;
    logic            misaligned_d;
`endif

    // Next-state value for the PC. Without the alignment option the mux
    // output is taken as-is, all XLEN bits. With it, the low two bits are
    // dropped so fetch always sees a word address, and the fact that they
    // were set is remembered separately in misaligned_d.
    always_comb begin
        pc_d = bus.pc_next;
`ifdef PC_ALIGN_CHECK_EN
        misaligned_d = (bus.pc_next[1:0] != 2'b00);
        pc_d         = {bus.pc_next[XLEN-1:2], 2'b00};
`endif
    end

    // PC and valid-flag register. Reset is asynchronous so the core jumps to
    // RESET_VECTOR the instant rst rises, throwing away whatever pc_next was
    // in flight (including X/Z from an uninitialised mux). The first edge
    // after release loads pc_next and raises pc_valid, which then stays high
    // until the next reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= RESET_VECTOR;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            valid_q <= 1'b1;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    // Misalignment flag register, reset alongside the PC so it can never
    // report a stale fault from before the reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misaligned_q <= 1'b0;
        end else begin
            misaligned_q <= misaligned_d;
        end
    end

    assign bus.pc_misaligned = misaligned_q;
`endif

    // Output drive. pc_plus4 is derived from the registered PC only and
    // wraps naturally at 2^XLEN because the sum is truncated to XLEN bits.
    assign bus.pc       = pc_q;
    assign bus.pc_plus4 = pc_q + XLEN'(4);
    assign bus.pc_valid = valid_q;

endmodule

// File: tb/tb_pc_reg.sv
// -----------------------------------------------------------------------------
// tb_pc_reg
//
// Purpose:
//   Self-checking bench for pc_reg. Each directed step drives pc_next and
//   pushes the outputs it should produce onto a scoreboard queue; the
//   matching check pops that entry and compares it against the DUT.
//
// Configuration macro:
//   PC_ALIGN_CHECK_EN   must match the RTL build; selects the masked-load
//                       expectations and the pc_misaligned checks.
// -----------------------------------------------------------------------------
module tb_pc_reg;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic [31:0] plus4;
        logic        valid;
        logic        mis;
    } expect_t;

    logic    clk;
    logic    rst;
    int      checks;
    int      errors;
    expect_t scoreboard[$];

    pc_reg_if #(.XLEN(32)) bus ();

    pc_reg #(
        .XLEN         (32),
        .RESET_VECTOR (32'h0000_0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run can never hang.
    initial begin
        #5000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] simulation did not finish");
    end

    // Drive pc_next and record what the DUT outputs should be at the next
    // sampling point.
    task automatic applyStimulus(input logic [31:0] nxt, input string tag,
                                 input logic [31:0] expPc,
                                 input logic [31:0] expPlus4,
                                 input logic expValid, input logic expMis);
        expect_t e;
        bus.pc_next = nxt;
        e.tag   = tag;
        e.pc    = expPc;
        e.plus4 = expPlus4;
        e.valid = expValid;
        e.mis   = expMis;
        scoreboard.push_back(e);
    endtask

    // Pop the oldest expectation and compare it against the DUT outputs.
    task automatic checkOutput();
        expect_t e;
        checks++;
        assert (scoreboard.size() != 0) else begin
            errors++;
            $error("[TB] FAIL scoreboard_empty observed 0 entries required >0");
        end
        if (scoreboard.size() != 0) begin
            e = scoreboard.pop_front();
            checks++;
            assert (bus.pc === e.pc) else begin
                errors++;
                $error("[TB] FAIL %s pc observed %h expected %h", e.tag, bus.pc, e.pc);
            end
            checks++;
            assert (bus.pc_plus4 === e.plus4) else begin
                errors++;
                $error("[TB] FAIL %s pc_plus4 observed %h expected %h", e.tag, bus.pc_plus4, e.plus4);
            end
            checks++;
            assert (bus.pc_valid === e.valid) else begin
                errors++;
                $error("[TB] FAIL %s pc_valid observed %b expected %b", e.tag, bus.pc_valid, e.valid);
            end
`ifdef PC_ALIGN_CHECK_EN
            checks++;
            assert (bus.pc_misaligned === e.mis) else begin
                errors++;
                $error("[TB] FAIL %s pc_misaligned observed %b expected %b", e.tag, bus.pc_misaligned, e.mis);
            end
`endif
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // Power-up reset; an X on pc_next across the edge at 5 ns must not leak.
        rst         = 1'b1;
        bus.pc_next = 32'h0;
        #1;
        applyStimulus('x, "reset_x", 32'h0, 32'h4, 1'b0, 1'b0);
        #6;
        checkOutput();

        // Release at 12 ns and load a few sequential addresses.
        #5;
        rst = 1'b0;
        applyStimulus(32'h4, "load4", 32'h4, 32'h8, 1'b1, 1'b0);
        @(posedge clk); #1;
        checkOutput();
        applyStimulus(32'h8, "load8", 32'h8, 32'hC, 1'b1, 1'b0);
        @(posedge clk); #1;
        checkOutput();
        applyStimulus(32'h20, "load20", 32'h20, 32'h24, 1'b1, 1'b0);
        @(posedge clk); #1;
        checkOutput();

        // Asynchronous reset between edges; the pending pc_next is dropped.
        #2;
        rst = 1'b1;
        applyStimulus(32'h10, "async_rst", 32'h0, 32'h4, 1'b0, 1'b0);
        #1;
        checkOutput();

        // Recovery: first edge after release loads pc_next and sets valid.
        #1;
        rst = 1'b0;
        applyStimulus(32'h10, "recover", 32'h10, 32'h14, 1'b1, 1'b0);
        @(posedge clk); #1;
        checkOutput();

        // Changing pc_next mid-cycle must not reach any output.
        applyStimulus(32'h100, "no_comb", 32'h10, 32'h14, 1'b1, 1'b0);
        #1;
        checkOutput();
        applyStimulus(32'h100, "load100", 32'h100, 32'h104, 1'b1, 1'b0);
        @(posedge clk); #1;
        checkOutput();

        // pc_plus4 wraps at 2^32.
        applyStimulus(32'hFFFF_FFFC, "wrap", 32'hFFFF_FFFC, 32'h0, 1'b1, 1'b0);
        @(posedge clk); #1;
        checkOutput();

        // Low-bit handling: masked with the option, verbatim without.
`ifdef PC_ALIGN_CHECK_EN
        applyStimulus(32'h6, "mis6", 32'h4, 32'h8, 1'b1, 1'b1);
`else
        applyStimulus(32'h6, "mis6", 32'h6, 32'hA, 1'b1, 1'b0);
`endif
        @(posedge clk); #1;
        checkOutput();
        applyStimulus(32'h8, "aligned8", 32'h8, 32'hC, 1'b1, 1'b0);
        @(posedge clk); #1;
        checkOutput();
`ifdef PC_ALIGN_CHECK_EN
        applyStimulus(32'hFFFF_FFFF, "all_ones", 32'hFFFF_FFFC, 32'h0, 1'b1, 1'b1);
`else
        applyStimulus(32'hFFFF_FFFF, "all_ones", 32'hFFFF_FFFF, 32'h3, 1'b1, 1'b0);
`endif
        @(posedge clk); #1;
        checkOutput();

        // Second asynchronous reset clears everything again.
        #2;
        rst = 1'b1;
        applyStimulus(32'h40, "rst_again", 32'h0, 32'h4, 1'b0, 1'b0);
        #1;
        checkOutput();

        checks++;
        assert (scoreboard.size() == 0) else begin
            errors++;
            $error("[TB] FAIL scoreboard_drain observed %0d entries required 0", scoreboard.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
